instr_fetch_unit: RTL

//  Fetch stage feeding the MIPS-lite decode/control path. Holds the PC and fetches
//  one 32-bit word per instruction over a req/ack imem port, with variable latency.

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, imem fetch FSM, instruction register and next-PC select (optional FETCH_ALIGN_CHECK_EN)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT_MAX = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        take_branch,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        reg_jump,
    input  logic [31:0] reg_target,
    output logic        fetch_timeout,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        FAULT = 2'd3
`endif
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;

    assign pc_plus4    = pc + 32'd4;
    assign opcode      = instr[31:26];
    assign imem_addr   = pc;
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == VALID);

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = (state_q == FAULT);
    assign next_pc     = next_pc_raw;
`else
    assign fetch_fault = 1'b0;
    // Without the alignment check a misaligned target is silently word-aligned.
    assign next_pc     = next_pc_raw & ~32'h0000_0003;
`endif

    // Redirect priority: register target, then jump, then taken branch, then sequential.
    always_comb begin
        next_pc_raw = pc_plus4;
        if (reg_jump) begin
            next_pc_raw = reg_target;
        end else if (jump) begin
            next_pc_raw = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (take_branch) begin
            next_pc_raw = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
        end
    end

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; acks are only honoured while fetching.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imem_ack) state_d = VALID;
            VALID: begin
                if (advance) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    state_d = (next_pc[1:0] != 2'b00) ? FAULT : FETCH;
`else
                    state_d = FETCH;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: state_d = FAULT;
`endif
            default: state_d = IDLE;
        endcase
    end

    // PC, instruction register and the fetch-wait watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            instr         <= 32'h0;
            wait_cnt      <= 8'd0;
            fetch_timeout <= 1'b0;
        end else begin
            fetch_timeout <= 1'b0;
            if (state_q == FETCH && imem_ack) begin
                instr <= imem_rdata;
            end
            if (state_q == VALID && advance) begin
                pc <= next_pc;
            end
            if (state_q == FETCH && !imem_ack) begin
                // Saturating at TIMEOUT_MAX keeps the pulse from repeating until an ack.
                if (wait_cnt != TIMEOUT_MAX) begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (wait_cnt == TIMEOUT_MAX - 8'd1) begin
                        fetch_timeout <= 1'b1;
                    end
                end
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

endmodule
